regfile_fwd: RTL and testbench

Parametrised general-purpose register file for the pipelined datapath.
- Two combinational read ports with write-to-read bypass.
- One general write-back port and one dedicated accumulator (R0) write port.
- Per-register pending-write scoreboard that flags RAW hazards to the pipeline controller.
- Sequenced clear-all engine that replaces the old "both loads asserted" clear encoding.

---
 rtl/regfile_fwd_pkg.sv | 14 +
 rtl/regfile_fwd_if.sv | 41 ++++
 rtl/regfile_scoreboard.sv | 50 +++++
 rtl/regfile_fwd.sv | 131 +++++++++++++
 tb/tb_regfile_fwd.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_fwd_pkg.sv
// Shared definitions for the register file: default sizes and the clear-engine state encoding.
package regfile_fwd_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 16;
  localparam int CLR_STATE_W  = 2;

  typedef enum logic [CLR_STATE_W-1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/regfile_fwd_if.sv
// Pipeline-facing bundle of the register file: read, write-back, reservation and clear signals.
interface regfile_fwd_if
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) ();

  localparam int SEL_W = $clog2(NUM_REGS);

  logic [SEL_W-1:0]  rd_sel_a;
  logic [SEL_W-1:0]  rd_sel_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] r0_data;
  logic              wr_en;
  logic [SEL_W-1:0]  wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic              acc_wr_en;
  logic [DATA_W-1:0] acc_data;
  logic              resv_en;
  logic [SEL_W-1:0]  resv_sel;
  logic              busy_a;
  logic              busy_b;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output rd_sel_a, rd_sel_b, wr_en, wr_sel, wr_data, acc_wr_en, acc_data,
           resv_en, resv_sel, clr_req,
    input  rd_data_a, rd_data_b, r0_data, busy_a, busy_b, clr_busy, clr_done
  );

  modport slave (
    input  rd_sel_a, rd_sel_b, wr_en, wr_sel, wr_data, acc_wr_en, acc_data,
           resv_en, resv_sel, clr_req,
    output rd_data_a, rd_data_b, r0_data, busy_a, busy_b, clr_busy, clr_done
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register marking an outstanding producer.
// A new reservation beats a same-cycle commit to the same register.
module regfile_scoreboard
  import regfile_fwd_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             resv_en,
  input  logic [SEL_W-1:0] resv_sel,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic             acc_wr_en,
  input  logic             clr_en,
  input  logic [SEL_W-1:0] clr_sel,
  input  logic [SEL_W-1:0] rd_sel_a,
  input  logic [SEL_W-1:0] rd_sel_b,
  input  logic             hit_a,
  input  logic             hit_b,
  input  logic             force_busy,
  output logic             busy_a,
  output logic             busy_b
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // Decode this cycle's reservations and committed writes into per-register set/clear masks.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (resv_en)   set_vec[resv_sel] = 1'b1;
    if (wr_en)     clr_vec[wr_sel]   = 1'b1;
    if (acc_wr_en) clr_vec[0]        = 1'b1;
    if (clr_en)    clr_vec[clr_sel]  = 1'b1;
  end

  // Update pending bits; set wins over clear so the newest producer stays tracked.
  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= set_vec | (pending & ~clr_vec);
  end

  assign busy_a = force_busy || (pending[rd_sel_a] && !hit_a);
  assign busy_b = force_busy || (pending[rd_sel_b] && !hit_b);

endmodule

// File: rtl/regfile_fwd.sv
// Register file with write-to-read bypass, dedicated accumulator port, hazard scoreboard
// and a sequenced clear-all engine that walks every register once.
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input logic          clk,
  input logic          rst_n,
  regfile_fwd_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  clr_state_t        state;
  logic [SEL_W-1:0]  clr_idx;
  logic              clr_busy_q;
  logic              clr_done_q;

  logic acc_we;
  logic wr_we;
  logic resv_we;
  logic acc_hit_a;
  logic acc_hit_b;
  logic wr_hit_a;
  logic wr_hit_b;

  // While clearing, all pipeline writes and reservations are locked out.
  // A general write aimed at R0 loses to a same-cycle accumulator write.
  assign acc_we  = bus.acc_wr_en && !clr_busy_q;
  assign wr_we   = bus.wr_en && !clr_busy_q && !(acc_we && bus.wr_sel == '0);
  assign resv_we = bus.resv_en && !clr_busy_q;

  assign acc_hit_a = acc_we && bus.rd_sel_a == '0;
  assign acc_hit_b = acc_we && bus.rd_sel_b == '0;
  assign wr_hit_a  = wr_we && bus.wr_sel == bus.rd_sel_a;
  assign wr_hit_b  = wr_we && bus.wr_sel == bus.rd_sel_b;

  assign bus.rd_data_a = acc_hit_a ? bus.acc_data :
                         wr_hit_a  ? bus.wr_data  : regs[bus.rd_sel_a];
  assign bus.rd_data_b = acc_hit_b ? bus.acc_data :
                         wr_hit_b  ? bus.wr_data  : regs[bus.rd_sel_b];
  assign bus.r0_data   = acc_we                        ? bus.acc_data :
                         (wr_we && bus.wr_sel == '0)   ? bus.wr_data  : regs[0];

  assign bus.clr_busy = clr_busy_q;
  assign bus.clr_done = clr_done_q;

  // Register array: reset zeroes everything, the clear engine zeroes one entry per cycle,
  // otherwise the write-back and accumulator ports commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (clr_busy_q) begin
      regs[clr_idx] <= '0;
    end else begin
      if (wr_we)  regs[bus.wr_sel] <= bus.wr_data;
      if (acc_we) regs[0]          <= bus.acc_data;
    end
  end

  // Clear engine: IDLE waits for a request, CLEAR walks the index, DONE pulses completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CLR_IDLE;
      clr_idx    <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      case (state)
        CLR_IDLE: begin
          clr_done_q <= 1'b0;
          if (bus.clr_req) begin
            state      <= CLR_CLEAR;
            clr_idx    <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        CLR_CLEAR: begin
          if (clr_idx == SEL_W'(NUM_REGS - 1)) begin
            state      <= CLR_DONE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        CLR_DONE: begin
          clr_done_q <= 1'b0;
          if (bus.clr_req) begin
            state      <= CLR_CLEAR;
            clr_idx    <= '0;
            clr_busy_q <= 1'b1;
          end else begin
            state <= CLR_IDLE;
          end
        end
        default: begin
          state      <= CLR_IDLE;
          clr_busy_q <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .resv_en    (resv_we),
    .resv_sel   (bus.resv_sel),
    .wr_en      (wr_we),
    .wr_sel     (bus.wr_sel),
    .acc_wr_en  (acc_we),
    .clr_en     (clr_busy_q),
    .clr_sel    (clr_idx),
    .rd_sel_a   (bus.rd_sel_a),
    .rd_sel_b   (bus.rd_sel_b),
    .hit_a      (acc_hit_a || wr_hit_a),
    .hit_b      (acc_hit_b || wr_hit_b),
    .force_busy (clr_busy_q),
    .busy_a     (bus.busy_a),
    .busy_b     (bus.busy_b)
  );

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed bench for regfile_fwd: reset, bypass, R0 priority, scoreboard and clear engine.
module tb_regfile_fwd;

  localparam int DW = 16;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  regfile_fwd_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();

  regfile_fwd #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    bus.wr_en     = 1'b0;
    bus.acc_wr_en = 1'b0;
    bus.resv_en   = 1'b0;
    bus.clr_req   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      bus.rd_sel_a = 4'(i);
      #1;
      checks++;
      if (bus.rd_data_a !== 16'h0000 || bus.busy_a !== 1'b0 || bus.clr_busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_read reg %0d: data=%h busy=%b clr_busy=%b, want 0000/0/0",
                 i, bus.rd_data_a, bus.busy_a, bus.clr_busy);
      end
    end
    checks++;
    if (bus.clr_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_clr_done: got %b want 0", bus.clr_done);
    end
  endtask

  task automatic test_bypass;
    bus.wr_en = 1'b1; bus.wr_sel = 4'd5; bus.wr_data = 16'hBEEF;
    bus.rd_sel_a = 4'd5; bus.rd_sel_b = 4'd6;
    #1;
    checks++;
    if (bus.rd_data_a !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL bypass_same_cycle: got %h want BEEF", bus.rd_data_a);
    end
    checks++;
    if (bus.rd_data_b !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL bypass_other_reg: got %h want 0000", bus.rd_data_b);
    end
    next_cycle();
    bus.wr_en = 1'b0;
    #1;
    checks++;
    if (bus.rd_data_a !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL bypass_committed: got %h want BEEF", bus.rd_data_a);
    end
  endtask

  task automatic test_r0_conflict;
    bus.acc_wr_en = 1'b1; bus.acc_data = 16'h0011;
    bus.wr_en = 1'b1; bus.wr_sel = 4'd0; bus.wr_data = 16'h0022;
    bus.rd_sel_a = 4'd0;
    #1;
    checks++;
    if (bus.r0_data !== 16'h0011 || bus.rd_data_a !== 16'h0011) begin
      errors++;
      $display("[TB] FAIL r0_conflict_comb: r0=%h a=%h want 0011", bus.r0_data, bus.rd_data_a);
    end
    next_cycle();
    drive_idle();
    #1;
    checks++;
    if (bus.r0_data !== 16'h0011 || bus.rd_data_a !== 16'h0011) begin
      errors++;
      $display("[TB] FAIL r0_conflict_stored: r0=%h a=%h want 0011", bus.r0_data, bus.rd_data_a);
    end
    bus.acc_wr_en = 1'b1; bus.acc_data = 16'h00AA;
    bus.wr_en = 1'b1; bus.wr_sel = 4'd7; bus.wr_data = 16'h0777;
    next_cycle();
    drive_idle();
    bus.rd_sel_a = 4'd0; bus.rd_sel_b = 4'd7;
    #1;
    checks++;
    if (bus.rd_data_a !== 16'h00AA || bus.rd_data_b !== 16'h0777) begin
      errors++;
      $display("[TB] FAIL dual_commit: a=%h b=%h want 00AA/0777", bus.rd_data_a, bus.rd_data_b);
    end
  endtask

  task automatic test_scoreboard;
    bus.resv_en = 1'b1; bus.resv_sel = 4'd3; bus.rd_sel_b = 4'd3;
    next_cycle();
    bus.resv_en = 1'b0;
    #1;
    checks++;
    if (bus.busy_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resv_sets_busy: got %b want 1", bus.busy_b);
    end
    bus.wr_en = 1'b1; bus.wr_sel = 4'd3; bus.wr_data = 16'h0007;
    #1;
    checks++;
    if (bus.busy_b !== 1'b0 || bus.rd_data_b !== 16'h0007) begin
      errors++;
      $display("[TB] FAIL write_hides_busy: busy=%b data=%h want 0/0007", bus.busy_b, bus.rd_data_b);
    end
    next_cycle();
    bus.wr_en = 1'b0;
    #1;
    checks++;
    if (bus.busy_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_clears_pending: got %b want 0", bus.busy_b);
    end
    bus.resv_en = 1'b1; bus.resv_sel = 4'd3;
    bus.wr_en = 1'b1; bus.wr_sel = 4'd3; bus.wr_data = 16'h0007;
    next_cycle();
    drive_idle();
    bus.rd_sel_a = 4'd3;
    #1;
    checks++;
    if (bus.busy_b !== 1'b1 || bus.busy_a !== 1'b1 || bus.rd_data_b !== 16'h0007) begin
      errors++;
      $display("[TB] FAIL resv_beats_write: busy_b=%b busy_a=%b data=%h want 1/1/0007",
               bus.busy_b, bus.busy_a, bus.rd_data_b);
    end
  endtask

  task automatic test_clear;
    for (int i = 1; i < NR; i++) begin
      bus.wr_en = 1'b1; bus.wr_sel = 4'(i); bus.wr_data = 16'(i);
      next_cycle();
    end
    drive_idle();
    bus.resv_en = 1'b1; bus.resv_sel = 4'd4;
    next_cycle();
    bus.resv_en = 1'b0;
    bus.rd_sel_a = 4'd4;
    #1;
    checks++;
    if (bus.busy_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL preclear_pending: got %b want 1", bus.busy_a);
    end
    bus.clr_req = 1'b1;
    bus.wr_en = 1'b1; bus.wr_sel = 4'd2; bus.wr_data = 16'hABCD;
    #1;
    checks++;
    if (bus.clr_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_busy_latency: got %b want 0", bus.clr_busy);
    end
    next_cycle();
    for (int c = 0; c < NR; c++) begin
      bus.wr_en = 1'b1; bus.wr_sel = 4'd15; bus.wr_data = 16'hFFFF;
      bus.acc_wr_en = 1'b1; bus.acc_data = 16'h1234;
      bus.resv_en = 1'b1; bus.resv_sel = 4'd9;
      bus.clr_req = 1'b1;
      bus.rd_sel_a = 4'd15; bus.rd_sel_b = 4'd2;
      #1;
      checks++;
      if (bus.clr_busy !== 1'b1 || bus.clr_done !== 1'b0 || bus.busy_a !== 1'b1) begin
        errors++;
        $display("[TB] FAIL clearing cycle %0d: clr_busy=%b clr_done=%b busy_a=%b want 1/0/1",
                 c, bus.clr_busy, bus.clr_done, bus.busy_a);
      end
      if (c == 0) begin
        checks++;
        if (bus.rd_data_a !== 16'h000F || bus.rd_data_b !== 16'hABCD || bus.r0_data !== 16'h00AA) begin
          errors++;
          $display("[TB] FAIL clear_no_bypass: a=%h b=%h r0=%h want 000F/ABCD/00AA",
                   bus.rd_data_a, bus.rd_data_b, bus.r0_data);
        end
      end
      next_cycle();
    end
    drive_idle();
    #1;
    checks++;
    if (bus.clr_done !== 1'b1 || bus.clr_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_done_pulse: done=%b busy=%b want 1/0", bus.clr_done, bus.clr_busy);
    end
    next_cycle();
    checks++;
    if (bus.clr_done !== 1'b0 || bus.clr_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_done_single: done=%b busy=%b want 0/0", bus.clr_done, bus.clr_busy);
    end
    for (int i = 0; i < NR; i++) begin
      bus.rd_sel_a = 4'(i);
      #1;
      checks++;
      if (bus.rd_data_a !== 16'h0000 || bus.busy_a !== 1'b0) begin
        errors++;
        $display("[TB] FAIL after_clear reg %0d: data=%h busy=%b want 0000/0", i, bus.rd_data_a, bus.busy_a);
      end
    end
  endtask

  task automatic test_back_to_back;
    int busy_cycles;
    bus.clr_req = 1'b1;
    next_cycle();
    bus.clr_req = 1'b0;
    for (int c = 0; c < NR; c++) next_cycle();
    bus.clr_req = 1'b1;
    #1;
    checks++;
    if (bus.clr_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_first_done: got %b want 1", bus.clr_done);
    end
    next_cycle();
    bus.clr_req = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < NR + 4; c++) begin
      #1;
      if (bus.clr_busy === 1'b1) busy_cycles++;
      if (bus.clr_done === 1'b1) break;
      next_cycle();
    end
    checks++;
    if (busy_cycles != NR || bus.clr_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_restart: busy cycles=%0d done=%b want %0d/1", busy_cycles, bus.clr_done, NR);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_clear;
    int done_pulses;
    bus.wr_en = 1'b1; bus.wr_sel = 4'd8; bus.wr_data = 16'h0088;
    next_cycle();
    drive_idle();
    bus.clr_req = 1'b1;
    next_cycle();
    bus.clr_req = 1'b0;
    for (int c = 0; c < 6; c++) next_cycle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.clr_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_clear_busy: got %b want 1", bus.clr_busy);
    end
    next_cycle();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_abandons_clear: busy=%b done=%b want 0/0", bus.clr_busy, bus.clr_done);
    end
    done_pulses = 0;
    for (int c = 0; c < NR + 4; c++) begin
      if (bus.clr_done === 1'b1) done_pulses++;
      next_cycle();
    end
    checks++;
    if (done_pulses != 0) begin
      errors++;
      $display("[TB] FAIL no_done_after_reset: pulses=%0d want 0", done_pulses);
    end
    for (int i = 0; i < NR; i++) begin
      bus.rd_sel_b = 4'(i);
      #1;
      checks++;
      if (bus.rd_data_b !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL after_reset_mid_clear reg %0d: got %h want 0000", i, bus.rd_data_b);
      end
    end
  endtask

  // Run every scenario in order and report.
  initial begin
    rst_n = 1'b0;
    drive_idle();
    bus.rd_sel_a = '0; bus.rd_sel_b = '0;
    bus.wr_sel = '0; bus.wr_data = '0;
    bus.acc_data = '0; bus.resv_sel = '0;
    next_cycle();
    test_reset();
    test_bypass();
    test_r0_conflict();
    test_scoreboard();
    test_clear();
    test_back_to_back();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
